// File: rtl/csa_sub_28bit_2stage_if.sv
// Operand/result bundle for csa_sub_28bit_2stage.
// CSA_SUB_STICKY_UF_EN adds the sticky-underflow clear/status pair.
interface csa_sub_28bit_2stage_if;
    logic        in_valid;
    logic [28:0] minuend;
    logic [27:0] subtrahend;
    logic        b_in;
    logic [27:0] diff;
    logic        underflow;
    logic        range_err;
    logic        out_valid;
`ifdef CSA_SUB_STICKY_UF_EN
    logic        uf_clr;
    logic        uf_sticky;

    modport master (
        output in_valid, minuend, subtrahend, b_in, uf_clr,
        input  diff, underflow, range_err, out_valid, uf_sticky
    );
    modport slave (
        input  in_valid, minuend, subtrahend, b_in, uf_clr,
        output diff, underflow, range_err, out_valid, uf_sticky
    );
`else
    modport master (
        output in_valid, minuend, subtrahend, b_in,
        input  diff, underflow, range_err, out_valid
    );
    modport slave (
        input  in_valid, minuend, subtrahend, b_in,
        output diff, underflow, range_err, out_valid
    );
`endif
endinterface

// File: rtl/csa_sub_28bit_2stage.sv
// Two-stage square-root carry-select subtractor: diff = minuend - subtrahend - b_in.
// Optional sticky underflow flag enabled by defining CSA_SUB_STICKY_UF_EN.
module csa_sub_28bit_2stage #(
    parameter int unsigned LAT = 2
) (
    input logic                    clk,
    input logic                    rstn,
    csa_sub_28bit_2stage_if.slave  sub_io
);

    if (LAT != 2) begin : g_lat_check
        $error("csa_sub_28bit_2stage supports LAT = 2 only");
    end

    // Block boundaries (sizes 1..5 in stage 1; 6, 7 and 1-bit tail in stage 2).
    localparam int unsigned S1Lo [6] = '{0, 1, 3, 6, 10, 15};
    localparam int unsigned S2Lo [4] = '{0, 6, 13, 14};

    function automatic logic [7:0] blk_add(input logic [6:0] a, input logic [6:0] b,
                                           input logic cin, input int unsigned w);
        logic [6:0] s;
        logic       c;
        s = '0;
        c = cin;
        for (int i = 0; i < 7; i++) begin
            if (i < int'(w)) begin
                s[i] = a[i] ^ b[i] ^ c;
                c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
            end
        end
        return {c, s};
    endfunction

    function automatic logic [7:0] blk_sel(input logic [6:0] a, input logic [6:0] b,
                                           input logic cin, input int unsigned w);
        logic [7:0] r0;
        logic [7:0] r1;
        r0 = blk_add(a, b, 1'b0, w);
        r1 = blk_add(a, b, 1'b1, w);
        return cin ? r1 : r0;
    endfunction

    logic [28:0] op_a, op_b;
    assign op_a = sub_io.minuend;
    assign op_b = ~{1'b0, sub_io.subtrahend};

    logic [14:0] lo_q, lo_d;
    logic        c15_q, c15_d;
    logic [13:0] a_hi_q, a_hi_d, b_hi_q, b_hi_d;
    logic        v1_q;
    logic [27:0] diff_q, diff_d;
    logic        uf_q, uf_d, re_q, re_d, ov_q;

    logic [21:0] a1_ext, b1_ext;
    logic [14:0] lo_sum;
    logic [7:0]  blk1;
    logic        c1;

    always_comb begin
        a1_ext = {7'd0, op_a[14:0]};
        b1_ext = {7'd0, op_b[14:0]};
        lo_sum = '0;
        blk1   = '0;
        c1     = ~sub_io.b_in;
        for (int k = 0; k < 5; k++) begin
            blk1   = blk_sel(a1_ext[S1Lo[k] +: 7], b1_ext[S1Lo[k] +: 7], c1,
                             S1Lo[k+1] - S1Lo[k]);
            lo_sum = lo_sum | 15'(22'(blk1[6:0]) << S1Lo[k]);
            c1     = blk1[7];
        end
        lo_d   = sub_io.in_valid ? lo_sum      : lo_q;
        c15_d  = sub_io.in_valid ? c1          : c15_q;
        a_hi_d = sub_io.in_valid ? op_a[28:15] : a_hi_q;
        b_hi_d = sub_io.in_valid ? op_b[28:15] : b_hi_q;
    end

    logic [19:0] a2_ext, b2_ext;
    logic [13:0] hi_sum;
    logic [7:0]  blk2;
    logic        c2;

    always_comb begin
        a2_ext = {6'd0, a_hi_q};
        b2_ext = {6'd0, b_hi_q};
        hi_sum = '0;
        blk2   = '0;
        c2     = c15_q;
        for (int k = 0; k < 3; k++) begin
            blk2   = blk_sel(a2_ext[S2Lo[k] +: 7], b2_ext[S2Lo[k] +: 7], c2,
                             S2Lo[k+1] - S2Lo[k]);
            hi_sum = hi_sum | 14'(20'(blk2[6:0]) << S2Lo[k]);
            c2     = blk2[7];
        end
        // c2 is now the no-borrow carry out of bit 28.
        diff_d = v1_q ? {hi_sum[12:0], lo_q} : diff_q;
        uf_d   = v1_q ? ~c2                  : uf_q;
        re_d   = v1_q ? (c2 & hi_sum[13])    : re_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lo_q   <= '0;
            c15_q  <= 1'b0;
            a_hi_q <= '0;
            b_hi_q <= '0;
            v1_q   <= 1'b0;
            diff_q <= '0;
            uf_q   <= 1'b0;
            re_q   <= 1'b0;
            ov_q   <= 1'b0;
        end else begin
            lo_q   <= lo_d;
            c15_q  <= c15_d;
            a_hi_q <= a_hi_d;
            b_hi_q <= b_hi_d;
            v1_q   <= sub_io.in_valid;
            diff_q <= diff_d;
            uf_q   <= uf_d;
            re_q   <= re_d;
            ov_q   <= v1_q;
        end
    end

    assign sub_io.diff      = diff_q;
    assign sub_io.underflow = uf_q;
    assign sub_io.range_err = re_q;
    assign sub_io.out_valid = ov_q;

`ifdef CSA_SUB_STICKY_UF_EN
    logic sticky_q, sticky_d;

    // Set takes priority over a same-cycle clear.
    always_comb begin
        sticky_d = sticky_q;
        if (sub_io.uf_clr) sticky_d = 1'b0;
        if (v1_q && (uf_d || re_d)) sticky_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) sticky_q <= 1'b0;
        else       sticky_q <= sticky_d;
    end

    assign sub_io.uf_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_csa_sub_28bit_2stage.sv
// Self-checking bench for csa_sub_28bit_2stage: random and directed vectors vs. arithmetic model.
// Exercises the sticky flag when CSA_SUB_STICKY_UF_EN is defined.
module tb_csa_sub_28bit_2stage;

    logic clk;
    logic rstn;
    int   errors;
    int   checks;

    csa_sub_28bit_2stage_if sub_if ();

    csa_sub_28bit_2stage #(.LAT(2)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .sub_io (sub_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {underflow, range_err, diff} from signed arithmetic.
    function automatic logic [29:0] ref_sub(input logic [28:0] m, input logic [27:0] s,
                                            input logic b);
        longint r;
        logic   uf, re;
        logic [63:0] ru;
        r  = longint'(m) - longint'(s) - longint'(b);
        uf = (r < 0);
        re = !uf && (r >= 64'sd268435456);
        ru = r;
        return {uf, re, ru[27:0]};
    endfunction

    task automatic drive(input logic v, input logic [28:0] m, input logic [27:0] s,
                         input logic b);
        sub_if.in_valid   = v;
        sub_if.minuend    = m;
        sub_if.subtrahend = s;
        sub_if.b_in       = b;
    endtask

    task automatic test_reset;
        drive(1'b1, 29'h1234567, 28'h0000123, 1'b0);
        rstn = 1'b0;
        #1;
        checks++;
        if (sub_if.out_valid !== 1'b0 || sub_if.diff !== 28'd0 ||
            sub_if.underflow !== 1'b0 || sub_if.range_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got ov=%b diff=%h uf=%b re=%b required all 0",
                     sub_if.out_valid, sub_if.diff, sub_if.underflow, sub_if.range_err);
        end
`ifdef CSA_SUB_STICKY_UF_EN
        checks++;
        if (sub_if.uf_sticky !== 1'b0) begin
            errors++;
            $display("FAIL reset_sticky: got %b required 0", sub_if.uf_sticky);
        end
`endif
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        drive(1'b0, '0, '0, 1'b0);
        @(posedge clk);
    endtask

    task automatic test_round_trip;
        logic [27:0] a_vec [100];
        logic [27:0] b_vec [100];
        for (int i = 0; i < 100; i++) begin
            a_vec[i] = 28'($urandom);
            b_vec[i] = 28'($urandom);
        end
        for (int i = 0; i < 102; i++) begin
            @(posedge clk);
            #1;
            if (i >= 2) begin
                checks++;
                if (sub_if.out_valid !== 1'b1 || sub_if.diff !== a_vec[i-2] ||
                    sub_if.underflow !== 1'b0 || sub_if.range_err !== 1'b0) begin
                    errors++;
                    $display("FAIL round_trip[%0d]: got ov=%b diff=%h uf=%b re=%b required 1 %h 0 0",
                             i - 2, sub_if.out_valid, sub_if.diff, sub_if.underflow,
                             sub_if.range_err, a_vec[i-2]);
                end
            end
            if (i < 100) drive(1'b1, {1'b0, a_vec[i]} + {1'b0, b_vec[i]}, b_vec[i], 1'b0);
            else         drive(1'b0, '0, '0, 1'b0);
        end
    endtask

    task automatic test_random;
        logic [29:0] exp_q [$];
        logic [29:0] e;
        logic [28:0] m;
        logic [27:0] s;
        logic        b;
        for (int i = 0; i < 62; i++) begin
            @(posedge clk);
            #1;
            if (i >= 2) begin
                e = exp_q.pop_front();
                checks++;
                if (sub_if.out_valid !== 1'b1 ||
                    {sub_if.underflow, sub_if.range_err, sub_if.diff} !== e ||
                    (sub_if.underflow && sub_if.range_err)) begin
                    errors++;
                    $display("FAIL random[%0d]: got ov=%b uf=%b re=%b diff=%h required 1 %b %b %h",
                             i - 2, sub_if.out_valid, sub_if.underflow, sub_if.range_err,
                             sub_if.diff, e[29], e[28], e[27:0]);
                end
            end
            if (i < 60) begin
                m = 29'($urandom);
                s = 28'($urandom);
                b = 1'($urandom);
                if (i % 4 == 1) s = m[27:0];
                exp_q.push_back(ref_sub(m, s, b));
                drive(1'b1, m, s, b);
            end else begin
                drive(1'b0, '0, '0, 1'b0);
            end
        end
    endtask

    task automatic test_directed;
        logic [28:0] tm [7] = '{29'h0000005, 29'h10000000, 29'h10000000, 29'h0008000,
                               29'h1000000, 29'h0000000, 29'h1FFFFFFF};
        logic [27:0] ts [7] = '{28'h0000007, 28'h0, 28'h1, 28'h1, 28'h1, 28'h0, 28'h0};
        logic        tb [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [27:0] td [7] = '{28'hFFFFFFE, 28'h0000000, 28'hFFFFFFF, 28'h0007FFF,
                               28'h0FFFFFF, 28'hFFFFFFF, 28'hFFFFFFF};
        logic        tu [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        tr [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 7; k++) begin
            @(posedge clk);
            #1;
            drive(1'b1, tm[k], ts[k], tb[k]);
            @(posedge clk);
            #1;
            drive(1'b0, '0, '0, 1'b0);
            @(posedge clk);
            #1;
            checks++;
            if (sub_if.out_valid !== 1'b1 || sub_if.diff !== td[k] ||
                sub_if.underflow !== tu[k] || sub_if.range_err !== tr[k]) begin
                errors++;
                $display("FAIL directed[%0d]: got ov=%b diff=%h uf=%b re=%b required 1 %h %b %b",
                         k, sub_if.out_valid, sub_if.diff, sub_if.underflow,
                         sub_if.range_err, td[k], tu[k], tr[k]);
            end
        end
    endtask

    task automatic test_valid_gaps;
        logic        vld [20];
        logic [29:0] exp_r [20];
        logic [28:0] m;
        logic [27:0] s;
        logic [27:0] hold;
        hold = '0;
        for (int i = 0; i < 22; i++) begin
            @(posedge clk);
            #1;
            if (i >= 2) begin
                checks++;
                if (sub_if.out_valid !== vld[i-2]) begin
                    errors++;
                    $display("FAIL gap_valid[%0d]: got %b required %b", i - 2,
                             sub_if.out_valid, vld[i-2]);
                end
                if (vld[i-2]) hold = exp_r[i-2][27:0];
                if (i >= 2) begin
                    checks++;
                    if (sub_if.diff !== hold) begin
                        errors++;
                        $display("FAIL gap_diff[%0d]: got %h required %h", i - 2,
                                 sub_if.diff, hold);
                    end
                end
            end
            if (i < 20) begin
                vld[i]   = (i % 2 == 0);
                m        = 29'($urandom);
                s        = 28'($urandom);
                exp_r[i] = ref_sub(m, s, 1'b0);
                drive(vld[i], m, s, 1'b0);
            end else begin
                drive(1'b0, '0, '0, 1'b0);
            end
        end
    endtask

`ifdef CSA_SUB_STICKY_UF_EN
    task automatic test_sticky;
        @(posedge clk);
        #1;
        sub_if.uf_clr = 1'b1;
        @(posedge clk);
        #1;
        sub_if.uf_clr = 1'b0;
        checks++;
        if (sub_if.uf_sticky !== 1'b0) begin
            errors++;
            $display("FAIL sticky_clr0: got %b required 0", sub_if.uf_sticky);
        end
        drive(1'b1, 29'h0000009, 28'h0000003, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b1, 29'h0000003, 28'h0000009, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, '0, '0, 1'b0);
        checks++;
        if (sub_if.uf_sticky !== 1'b0) begin
            errors++;
            $display("FAIL sticky_no_uf: got %b required 0", sub_if.uf_sticky);
        end
        @(posedge clk);
        #1;
        checks++;
        if (sub_if.uf_sticky !== 1'b1) begin
            errors++;
            $display("FAIL sticky_set: got %b required 1", sub_if.uf_sticky);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sub_if.uf_sticky !== 1'b1) begin
            errors++;
            $display("FAIL sticky_hold: got %b required 1", sub_if.uf_sticky);
        end
        sub_if.uf_clr = 1'b1;
        @(posedge clk);
        #1;
        sub_if.uf_clr = 1'b0;
        checks++;
        if (sub_if.uf_sticky !== 1'b0) begin
            errors++;
            $display("FAIL sticky_clr: got %b required 0", sub_if.uf_sticky);
        end
    endtask
`endif

    task automatic test_reset_mid;
        logic [29:0] e;
        drive(1'b1, 29'h0ABCDEF, 28'h0012345, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b1, 29'h0000002, 28'h0000005, 1'b0);
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        checks++;
        if (sub_if.out_valid !== 1'b0 || sub_if.diff !== 28'd0 ||
            sub_if.underflow !== 1'b0 || sub_if.range_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got ov=%b diff=%h uf=%b re=%b required all 0",
                     sub_if.out_valid, sub_if.diff, sub_if.underflow, sub_if.range_err);
        end
        drive(1'b1, 29'h0F00000, 28'h0000ABC, 1'b1);
        e = ref_sub(29'h0F00000, 28'h0000ABC, 1'b1);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        checks++;
        if (sub_if.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_rel0: got ov=%b required 0", sub_if.out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (sub_if.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_rel1: got ov=%b required 0", sub_if.out_valid);
        end
        @(posedge clk);
        #1;
        drive(1'b0, '0, '0, 1'b0);
        checks++;
        if (sub_if.out_valid !== 1'b1 ||
            {sub_if.underflow, sub_if.range_err, sub_if.diff} !== e) begin
            errors++;
            $display("FAIL reset_first: got ov=%b diff=%h required 1 %h",
                     sub_if.out_valid, sub_if.diff, e[27:0]);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rstn   = 1'b1;
        drive(1'b0, '0, '0, 1'b0);
`ifdef CSA_SUB_STICKY_UF_EN
        sub_if.uf_clr = 1'b0;
`endif
        #2;
        test_reset();
        test_round_trip();
        test_random();
        test_directed();
        test_valid_gaps();
`ifdef CSA_SUB_STICKY_UF_EN
        test_sticky();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
